cacheline_adapter: RTL

- Bridges the 256-bit cacheline port of the L1 cache (read/write/resp) to the 64-bit banked burst memory interface (addr/read/write/wdata/ready/raddr/rdata/rvalid).
- Sits directly upstream of the banked memory model.
- Serialises line writes into 4-beat bursts and assembles 4-beat read bursts into one line.
- Keeps exactly one transaction outstanding.

---
 rtl/cacheline_adapter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/cacheline_adapter.sv
// cacheline_adapter
// -----------------------------------------------------------------------------
// Bridges the L1 cache's 256-bit line port to the 64-bit banked burst memory.
// A line write is serialised into BURST_LEN beats. BURST_LEN returning read
// beats are assembled into one line. Only one transaction is outstanding at a
// time. Every output is registered.
//
// Ports
//   clk          clock
//   rst          asynchronous reset, active-low
//   dfp_addr     cache line address (low line-offset bits ignored)
//   dfp_read     line read request (sampled in IDLE only)
//   dfp_write    line write request (sampled in IDLE only, wins over read)
//   dfp_wdata    line to write
//   dfp_rdata    last assembled read line, valid from the dfp_resp cycle on
//   dfp_resp     one-cycle completion pulse
//   bmem_addr    line-aligned burst address
//   bmem_read    burst read request, held until bmem_ready
//   bmem_write   write beat valid
//   bmem_wdata   write beat data
//   bmem_ready   memory accepts the request / beat this cycle
//   bmem_raddr   address tag of the returning read beat
//   bmem_rdata   read beat data
//   bmem_rvalid  read beat valid
// -----------------------------------------------------------------------------
module cacheline_adapter #(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       dfp_addr,
  input  logic              dfp_read,
  input  logic              dfp_write,
  input  logic [LINE_W-1:0] dfp_wdata,
  output logic [LINE_W-1:0] dfp_rdata,
  output logic              dfp_resp,
  output logic [31:0]       bmem_addr,
  output logic              bmem_read,
  output logic              bmem_write,
  output logic [BEAT_W-1:0] bmem_wdata,
  input  logic              bmem_ready,
  input  logic [31:0]       bmem_raddr,
  input  logic [BEAT_W-1:0] bmem_rdata,
  input  logic              bmem_rvalid
);

  localparam int BURST_LEN = LINE_W / BEAT_W;
  localparam int CNT_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int OFFSET_W  = $clog2(LINE_W / 8);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_DATA,
    WR_DATA,
    RESP
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  // Shared line buffer: holds the remaining write beats (shifted down as each
  // beat goes out) or the read beats collected so far (shifted in from the top).
  logic [LINE_W-1:0] r_line;
  logic [LINE_W-1:0] r_dfp_rdata;
  logic              r_dfp_resp;
  logic [31:0]       r_bmem_addr;
  logic              r_bmem_read;
  logic              r_bmem_write;
  logic [BEAT_W-1:0] r_bmem_wdata;

  logic [31:0]       w_aligned;
  logic              w_beat_hit;
  logic [LINE_W-1:0] w_line_next;
  logic              w_unused_offset;

  assign w_aligned       = {dfp_addr[31:OFFSET_W], {OFFSET_W{1'b0}}};
  assign w_unused_offset = ^dfp_addr[OFFSET_W-1:0];

  // Only beats tagged with our own line address belong to this burst; stray
  // beats for other lines are dropped without advancing the counter.
  assign w_beat_hit  = bmem_rvalid && (bmem_raddr == r_bmem_addr);

  // Shifting beats in from the top leaves beat 0 in the low bits after a full burst.
  assign w_line_next = {bmem_rdata, r_line[LINE_W-1:BEAT_W]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_line       <= '0;
      r_dfp_rdata  <= '0;
      r_dfp_resp   <= 1'b0;
      r_bmem_addr  <= '0;
      r_bmem_read  <= 1'b0;
      r_bmem_write <= 1'b0;
      r_bmem_wdata <= '0;
    end else begin
      r_dfp_resp <= 1'b0;
      case (r_state)
        IDLE: begin
          if (dfp_write) begin
            r_bmem_addr  <= w_aligned;
            r_bmem_write <= 1'b1;
            r_bmem_wdata <= dfp_wdata[BEAT_W-1:0];
            r_line       <= dfp_wdata >> BEAT_W;
            r_cnt        <= '0;
            r_state      <= WR_DATA;
          end else if (dfp_read) begin
            r_bmem_addr <= w_aligned;
            r_bmem_read <= 1'b1;
            r_cnt       <= '0;
            r_state     <= RD_REQ;
          end
        end

        RD_REQ: begin
          if (bmem_ready) begin
            r_bmem_read <= 1'b0;
            r_state     <= RD_DATA;
          end
        end

        RD_DATA: begin
          if (w_beat_hit) begin
            r_line <= w_line_next;
            r_cnt  <= r_cnt + CNT_W'(1);
            if (r_cnt == LAST_BEAT) begin
              r_dfp_rdata <= w_line_next;
              r_dfp_resp  <= 1'b1;
              r_state     <= RESP;
            end
          end
        end

        // bmem_write is always high here, so bmem_ready alone means acceptance.
        WR_DATA: begin
          if (bmem_ready) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == LAST_BEAT) begin
              r_bmem_write <= 1'b0;
              r_bmem_wdata <= '0;
              r_dfp_resp   <= 1'b1;
              r_state      <= RESP;
            end else begin
              r_bmem_wdata <= r_line[BEAT_W-1:0];
              r_line       <= r_line >> BEAT_W;
            end
          end
        end

        RESP: begin
          r_state <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign dfp_rdata  = r_dfp_rdata;
  assign dfp_resp   = r_dfp_resp;
  assign bmem_addr  = r_bmem_addr;
  assign bmem_read  = r_bmem_read;
  assign bmem_write = r_bmem_write;
  assign bmem_wdata = r_bmem_wdata;

endmodule
